mem_access_stage: RTL and testbench

- MEM-stage load/store unit between the EX/MEM register and the MEM/WB register; its outputs drive the MEM/WB inputs directly.
- Runs a req/ack handshake to data memory, with a timeout, and stalls the upstream pipeline while an access is outstanding.
- Generates byte enables, aligns store data, formats load data (sign/zero extension) and flags misaligned or illegal accesses.
- Non-memory instructions pass through combinationally with zero added latency.

---
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_access_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
// The request side is registered in the master; ack/rdata come straight from memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: req/ack data-memory access with timeout, upstream stall,
// byte-enable/store-lane generation, load extension and fault flagging.
// Non-memory instructions pass through combinationally.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [31:0]                alu_result_in,
  input  logic [31:0]                store_data_in,
  input  logic [4:0]                 rd_in,
  input  logic                       reg_write_in,
  input  logic                       mem_to_reg_in,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic [2:0]                 funct3_in,
  output logic [31:0]                mem_data_out,
  output logic [31:0]                alu_result_out,
  output logic [4:0]                 rd_out,
  output logic                       reg_write_out,
  output logic                       mem_to_reg_out,
  output logic                       stall_out,
  output logic                       fault_out,
  mem_access_stage_if.master         dmem
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [7:0] CntMax = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic [31:0] rdata_q, rdata_d;

  logic        is_load, is_store, mem_op, illegal, misaligned, access_fault, launch;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  // Decode access legality and build store lanes from the EX/MEM inputs.
  always_comb begin
    is_load    = mem_read_in;
    is_store   = mem_write_in & ~mem_read_in;
    mem_op     = valid_in & (mem_read_in | mem_write_in);
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3_in)
      3'b000:  misaligned = 1'b0;
      3'b001:  misaligned = alu_result_in[0];
      3'b010:  misaligned = |alu_result_in[1:0];
      3'b100:  illegal    = ~is_load;
      3'b101: begin
        illegal    = ~is_load;
        misaligned = alu_result_in[0];
      end
      default: illegal    = 1'b1;
    endcase
    access_fault = mem_op & (illegal | misaligned);
    launch       = mem_op & ~(illegal | misaligned);

    case (funct3_in[1:0])
      2'b00: begin
        store_be    = 4'b0001 << alu_result_in[1:0];
        store_wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << alu_result_in[1:0];
        store_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = store_data_in;
      end
    endcase
  end

  // Select and extend the captured read word by address offset and funct3.
  always_comb begin
    case (alu_result_in[1:0])
      2'b00:   ld_byte = rdata_q[7:0];
      2'b01:   ld_byte = rdata_q[15:8];
      2'b10:   ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = alu_result_in[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_in)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_data = rdata_q;
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = 32'h0;
    endcase
  end

  // Next-state logic: launch in IDLE, wait for ack or timeout in BUSY, retire in RESP.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    rdata_d   = rdata_q;
    case (state_q)
      StIdle: begin
        if (launch) begin
          state_d   = StBusy;
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {alu_result_in[31:2], 2'b00};
          wdata_d   = store_wdata;
          be_d      = is_load ? 4'b1111 : store_be;
          cnt_d     = 8'h0;
          timeout_d = 1'b0;
        end
      end
      StBusy: begin
        if (dmem.dmem_ack) begin
          rdata_d = dmem.dmem_rdata;
          req_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntMax) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and bus registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      cnt_q     <= 8'h0;
      timeout_q <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      rdata_q   <= rdata_d;
    end
  end

  // MEM/WB outputs; stalled cycles carry reg_write = 0 so MEM/WB sees a bubble.
  always_comb begin
    alu_result_out = alu_result_in;
    rd_out         = rd_in;
    reg_write_out  = reg_write_in;
    mem_to_reg_out = mem_to_reg_in;
    mem_data_out   = 32'h0;
    stall_out      = 1'b0;
    fault_out      = 1'b0;
    if (reset) begin
      alu_result_out = 32'h0;
      rd_out         = 5'h0;
      reg_write_out  = 1'b0;
      mem_to_reg_out = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access_fault) begin
            reg_write_out = 1'b0;
            fault_out     = 1'b1;
          end else if (launch) begin
            reg_write_out = 1'b0;
            stall_out     = 1'b1;
          end
        end
        StBusy: begin
          reg_write_out = 1'b0;
          stall_out     = 1'b1;
        end
        StResp: begin
          if (timeout_q) begin
            reg_write_out = 1'b0;
            fault_out     = 1'b1;
          end else if (mem_read_in) begin
            mem_data_out = load_data;
          end
        end
        default: stall_out = 1'b0;
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected completions and bus requests are
// queued at issue time and compared by a negedge monitor when the DUT presents them.
module tb_mem_access_stage;

  typedef struct packed {
    logic [31:0] mdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        regw;
    logic        m2r;
    logic        fault;
  } out_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_wdata;
  } req_t;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        mem_to_reg_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] mem_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        mem_to_reg_out;
  logic        stall_out;
  logic        fault_out;

  logic        auto_ack;
  logic [31:0] auto_rdata;
  logic        man_ack;
  logic [31:0] man_rdata;
  int          resp_wait;
  int          wait_cnt;
  logic        req_prev;

  out_t out_q[$];
  req_t req_q[$];
  int   checks;
  int   errors;

  mem_access_stage_if dmem_bus ();

  assign dmem_bus.dmem_ack   = auto_ack | man_ack;
  assign dmem_bus.dmem_rdata = man_ack ? man_rdata : auto_rdata;

  mem_access_stage #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .rd_in          (rd_in),
    .reg_write_in   (reg_write_in),
    .mem_to_reg_in  (mem_to_reg_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .funct3_in      (funct3_in),
    .mem_data_out   (mem_data_out),
    .alu_result_out (alu_result_out),
    .rd_out         (rd_out),
    .reg_write_out  (reg_write_out),
    .mem_to_reg_out (mem_to_reg_out),
    .stall_out      (stall_out),
    .fault_out      (fault_out),
    .dmem           (dmem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_in     = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
  endtask

  // Issue one instruction, queue its expectations, hold it until the stall releases.
  task automatic run_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic regw, input logic m2r,
                        input int wait_cyc, input logic [31:0] rdata,
                        input logic [31:0] exp_mdata, input logic exp_fault,
                        input int exp_stall, input logic exp_req,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    out_t o;
    req_t r;
    int   stalls;
    resp_wait  = wait_cyc;
    auto_rdata = rdata;
    o = '{exp_mdata, addr, rd, exp_fault ? 1'b0 : regw, m2r, exp_fault};
    out_q.push_back(o);
    if (exp_req) begin
      r = '{wr_en & ~rd_en, {addr[31:2], 2'b00}, exp_wdata, exp_be, wr_en & ~rd_en};
      req_q.push_back(r);
    end
    @(posedge clk);
    #1;
    valid_in      = 1'b1;
    mem_read_in   = rd_en;
    mem_write_in  = wr_en;
    funct3_in     = f3;
    alu_result_in = addr;
    store_data_in = sdata;
    rd_in         = rd;
    reg_write_in  = regw;
    mem_to_reg_in = m2r;
    stalls = 0;
    while (1) begin
      @(negedge clk);
      if (!stall_out) break;
      stalls++;
      if (stalls > 40) begin
        chk("stall bound expired", 128'(stalls), 128'd0);
        break;
      end
    end
    chk("stall cycles", 128'(stalls), 128'(exp_stall));
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    auto_ack   = 1'b0;
    auto_rdata = 32'h0;
    man_ack    = 1'b0;
    man_rdata  = 32'h0;
    resp_wait  = -1;
    wait_cnt   = 0;
    req_prev   = 1'b0;
    reset      = 1'b1;
    // Drive a live ADD during reset: every combinational output must still be zero.
    valid_in      = 1'b1;
    alu_result_in = 32'h5555_5555;
    store_data_in = 32'h0;
    rd_in         = 5'd3;
    reg_write_in  = 1'b1;
    mem_to_reg_in = 1'b1;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b0;
    funct3_in     = 3'b000;
    fork
      // Monitor: scoreboard pops on completion and on each new bus request.
      forever begin
        @(negedge clk);
        if (!reset && valid_in && !stall_out) begin
          if (out_q.size() == 0) chk("unexpected completion", 128'd1, 128'd0);
          else begin
            out_t e;
            out_t g;
            e = out_q.pop_front();
            g = '{mem_data_out, alu_result_out, rd_out, reg_write_out, mem_to_reg_out,
                  fault_out};
            chk("completion", 128'(g), 128'(e));
          end
        end
        if (dmem_bus.dmem_req && !req_prev) begin
          if (req_q.size() == 0) chk("unexpected request", 128'd1, 128'd0);
          else begin
            req_t e;
            req_t g;
            e = req_q.pop_front();
            g = '{dmem_bus.dmem_we, dmem_bus.dmem_addr,
                  e.chk_wdata ? dmem_bus.dmem_wdata : e.wdata, dmem_bus.dmem_be,
                  e.chk_wdata};
            chk("request", 128'(g), 128'(e));
          end
        end
        req_prev = dmem_bus.dmem_req;
      end
      // Memory responder: ack after resp_wait BUSY cycles; negative wait never acks.
      forever begin
        @(posedge clk);
        #1;
        if (auto_ack) begin
          auto_ack = 1'b0;
          wait_cnt = 0;
        end else if (dmem_bus.dmem_req && resp_wait >= 0) begin
          if (wait_cnt >= resp_wait) begin
            auto_ack = 1'b1;
            wait_cnt = 0;
          end else wait_cnt++;
        end else wait_cnt = 0;
      end
      begin
        @(negedge clk);
        chk("reset outputs", 128'({mem_data_out, alu_result_out, rd_out, reg_write_out,
                                   mem_to_reg_out, stall_out, fault_out}), 128'd0);
        @(posedge clk);
        #1;
        chk("reset bus", 128'({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr,
                               dmem_bus.dmem_wdata, dmem_bus.dmem_be}), 128'd0);
        reset = 1'b0;
        idle_inputs();

        //     rd wr f3      addr          sdata         rd  rw m2r wait rdata
        //     exp_mdata     flt stall req be       wdata
        run_op(0, 0, 3'b000, 32'h0000_1234, 32'h0,        5, 1, 0, -1, 32'h0,
               32'h0,         0, 0, 0, 4'h0,    32'h0);
        run_op(1, 0, 3'b000, 32'h0000_0103, 32'h0,        7, 1, 1,  2, 32'h80FF_0000,
               32'hFFFF_FF80, 0, 4, 1, 4'b1111, 32'h0);
        run_op(1, 0, 3'b100, 32'h0000_0103, 32'h0,        7, 1, 1,  2, 32'h80FF_0000,
               32'h0000_0080, 0, 4, 1, 4'b1111, 32'h0);
        run_op(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 9, 0, 0, 0, 32'h0,
               32'h0,         0, 2, 1, 4'b1100, 32'hABCD_ABCD);
        run_op(1, 0, 3'b010, 32'h0000_0301, 32'h0,       10, 1, 1, -1, 32'h0,
               32'h0,         1, 0, 0, 4'h0,    32'h0);
        run_op(1, 0, 3'b010, 32'h0000_0400, 32'h0,       11, 1, 1, -1, 32'h0,
               32'h0,         1, 5, 1, 4'b1111, 32'h0);
        run_op(1, 0, 3'b001, 32'h0000_0402, 32'h0,       12, 1, 1,  1, 32'h8001_7FFF,
               32'hFFFF_8001, 0, 3, 1, 4'b1111, 32'h0);
        run_op(1, 0, 3'b101, 32'h0000_0000, 32'h0,       12, 1, 1,  0, 32'h8001_7FFF,
               32'h0000_7FFF, 0, 2, 1, 4'b1111, 32'h0);
        run_op(0, 1, 3'b000, 32'h0000_0501, 32'h1234_5678, 2, 0, 0, 0, 32'h0,
               32'h0,         0, 2, 1, 4'b0010, 32'h7878_7878);
        run_op(0, 1, 3'b010, 32'h0000_0600, 32'hDEAD_BEEF, 2, 0, 0, 0, 32'h0,
               32'h0,         0, 2, 1, 4'b1111, 32'hDEAD_BEEF);
        run_op(0, 1, 3'b100, 32'h0000_0700, 32'h1,        4, 0, 0, -1, 32'h0,
               32'h0,         1, 0, 0, 4'h0,    32'h0);
        run_op(1, 0, 3'b011, 32'h0000_0708, 32'h0,        4, 1, 1, -1, 32'h0,
               32'h0,         1, 0, 0, 4'h0,    32'h0);
        run_op(1, 0, 3'b101, 32'h0000_0003, 32'h0,        4, 1, 1, -1, 32'h0,
               32'h0,         1, 0, 0, 4'h0,    32'h0);
        run_op(1, 1, 3'b100, 32'h0000_0801, 32'h0,       13, 1, 1,  0, 32'h0000_F000,
               32'h0000_00F0, 0, 2, 1, 4'b1111, 32'h0);
        run_op(1, 0, 3'b010, 32'h0000_0704, 32'h0,       14, 1, 1,  3, 32'hCAFE_F00D,
               32'hCAFE_F00D, 0, 5, 1, 4'b1111, 32'h0);

        // Reset in the second BUSY cycle aborts the access; a late ack must be ignored.
        resp_wait = -1;
        req_q.push_back('{1'b0, 32'h0000_0900, 32'h0, 4'b1111, 1'b0});
        @(posedge clk);
        #1;
        valid_in      = 1'b1;
        mem_read_in   = 1'b1;
        mem_write_in  = 1'b0;
        funct3_in     = 3'b010;
        alu_result_in = 32'h0000_0900;
        rd_in         = 5'd15;
        reg_write_in  = 1'b1;
        mem_to_reg_in = 1'b1;
        @(negedge clk);
        chk("stall on launch", 128'(stall_out), 128'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("still requesting", 128'(dmem_bus.dmem_req), 128'd1);
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("bus after abort", 128'({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr,
                                     dmem_bus.dmem_wdata, dmem_bus.dmem_be}), 128'd0);
        reset     = 1'b0;
        man_ack   = 1'b1;
        man_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        chk("late ack ignored", 128'({dmem_bus.dmem_req, stall_out}), 128'd0);
        run_op(1, 0, 3'b010, 32'h0000_0904, 32'h0,       16, 1, 1,  0, 32'h1122_3344,
               32'h1122_3344, 0, 2, 1, 4'b1111, 32'h0);

        repeat (2) @(posedge clk);
        chk("scoreboard drained", 128'(out_q.size() + req_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    join
  end

endmodule
